// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for mix_columns_seq: input state channel and output result channel.
// Optional MIXCOLUMNS_INV_EN adds the inv_mode select travelling with the input state.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef MIXCOLUMNS_INV_EN
  logic         inv_mode;

  modport master (
    output in_valid, in_data, out_ready, inv_mode,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, out_ready, inv_mode,
    output in_ready, out_valid, out_data
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns: one 32-bit column per clock, four clocks per state.
// Define MIXCOLUMNS_INV_EN to add a latched inv_mode select for InvMixColumns.
module mix_columns_seq (
  input  logic            clk,
  input  logic            rst_n,
  mix_columns_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_cnt_q;
  logic [127:0] data_q, data_d;
  logic [31:0]  col_in, col_out;
  logic         accept;
  logic         inv_q;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] t0, t1, t2, t3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    t0 = xtime(a0);
    t1 = xtime(a1);
    t2 = xtime(a2);
    t3 = xtime(a3);
    return {t0 ^ (t1 ^ a1) ^ a2 ^ a3,
            a0 ^ t1 ^ (t2 ^ a2) ^ a3,
            a0 ^ a1 ^ t2 ^ (t3 ^ a3),
            (t0 ^ a0) ^ a1 ^ a2 ^ t3};
  endfunction

  // Multiples 9, B, D, E of one byte, built from x, 2x, 4x, 8x.
  function automatic logic [31:0] inv_mults(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    // Packed as {E, B, D, 9}, matching the row-0 coefficient order.
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ x, x8 ^ x4 ^ x, x8 ^ x};
  endfunction

  function automatic logic [31:0] mix_inv(input logic [31:0] a);
    logic [31:0] m0, m1, m2, m3;
    m0 = inv_mults(a[31:24]);
    m1 = inv_mults(a[23:16]);
    m2 = inv_mults(a[15:8]);
    m3 = inv_mults(a[7:0]);
    // Field order within m*: [31:24]=E, [23:16]=B, [15:8]=D, [7:0]=9.
    return {m0[31:24] ^ m1[23:16] ^ m2[15:8]  ^ m3[7:0],
            m0[7:0]   ^ m1[31:24] ^ m2[23:16] ^ m3[15:8],
            m0[15:8]  ^ m1[7:0]   ^ m2[31:24] ^ m3[23:16],
            m0[23:16] ^ m1[15:8]  ^ m2[7:0]   ^ m3[31:24]};
  endfunction

  assign accept = bus.in_valid && (state_q == StIdle);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid) state_d = StBusy;
      StBusy:  if (col_cnt_q == 2'd3) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs; the working register is the result.
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.out_data  = data_q;
  end

  // Column select and transform of the column under work.
  always_comb begin
    col_in = 32'h0;
    unique case (col_cnt_q)
      2'd0: col_in = data_q[127:96];
      2'd1: col_in = data_q[95:64];
      2'd2: col_in = data_q[63:32];
      2'd3: col_in = data_q[31:0];
      default: col_in = 32'h0;
    endcase
    col_out = inv_q ? mix_inv(col_in) : mix_fwd(col_in);
  end

  // Working register next value: load on accept, else rewrite only the current column.
  always_comb begin
    data_d = data_q;
    if (accept) begin
      data_d = bus.in_data;
    end else if (state_q == StBusy) begin
      unique case (col_cnt_q)
        2'd0: data_d[127:96] = col_out;
        2'd1: data_d[95:64]  = col_out;
        2'd2: data_d[63:32]  = col_out;
        2'd3: data_d[31:0]   = col_out;
        default: data_d = data_q;
      endcase
    end
  end

  // Datapath registers: working state and column counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= 128'h0;
      col_cnt_q <= 2'd0;
    end else begin
      data_q <= data_d;
      if (accept) begin
        col_cnt_q <= 2'd0;
      end else if (state_q == StBusy) begin
        col_cnt_q <= col_cnt_q + 2'd1;
      end
    end
  end

`ifdef MIXCOLUMNS_INV_EN
  // Mode is captured with the state so mid-operation changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else if (accept) begin
      inv_q <= bus.inv_mode;
    end
  end
`else
  assign inv_q = 1'b0;
`endif

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq; reference uses generic GF(2^8) multiply
// with a rotated coefficient row. Inverse tests run when MIXCOLUMNS_INV_EN is defined.
module tb_mix_columns_seq;

  logic clk;
  logic rst_n;
  mix_columns_seq_if bus ();

  mix_columns_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int in_fires = 0;
  int out_fires = 0;
  int aborts = 0;
  logic cur_inv = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Peasant multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0] base [4];
    logic [7:0] a [4];
    logic [7:0] b;
    logic [127:0] r = 128'h0;
    if (inv) begin
      base[0] = 8'h0E; base[1] = 8'h0B; base[2] = 8'h0D; base[3] = 8'h09;
    end else begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h0;
        for (int k = 0; k < 4; k++) b ^= gmul(base[(k - row) & 3], a[k]);
        r[127 - 32*c - 8*row -: 8] = b;
      end
    end
    return r;
  endfunction

  // Handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) in_fires++;
      if (bus.out_valid && bus.out_ready) out_fires++;
    end
  end

  task automatic send(input logic [127:0] d);
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
`ifdef MIXCOLUMNS_INV_EN
    bus.inv_mode = cur_inv;
`endif
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check_eq("accept", 128'(acc), 128'd1);
  endtask

  // Full operation: accept, check latency and result, stall, complete handshake.
  task automatic run_op(input logic [127:0] d, input logic [127:0] exp, input int stall,
                        input bit toggle, input bit inject, input logic [127:0] d2);
    int cyc = 0;
    bus.out_ready = (stall == 0);
    send(d);
    while (!bus.out_valid && cyc < 20) begin
`ifdef MIXCOLUMNS_INV_EN
      if (toggle) bus.inv_mode = ~bus.inv_mode;
`endif
      @(posedge clk);
      #1;
      cyc++;
    end
`ifdef MIXCOLUMNS_INV_EN
    bus.inv_mode = cur_inv;
`endif
    check_eq("latency", 128'(cyc), 128'd4);
    check_eq("result", bus.out_data, exp);
    if (inject) begin
      bus.in_valid = 1'b1;
      bus.in_data  = d2;
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      check_eq("stall_data", bus.out_data, exp);
      check_eq("stall_ready", {bus.in_ready, bus.out_valid}, 2'b01);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("hs_done", {bus.in_ready, bus.out_valid}, 2'b10);
    bus.out_ready = 1'b0;
  endtask

  logic [127:0] v, e, fw;
  initial begin
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 128'h0;
    bus.out_ready = 1'b0;
`ifdef MIXCOLUMNS_INV_EN
    bus.inv_mode  = 1'b0;
`endif
    #12;
    check_eq("rst_ctrl", {bus.in_ready, bus.out_valid}, 2'b10);
    check_eq("rst_data", bus.out_data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 column vector.
    v = 128'hdb135345_f20a225c_01010101_2d26314c;
    check_eq("fips_model", model(v, 1'b0), 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
    run_op(v, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 0, 1'b0, 1'b0, 128'h0);

    // Reduction path and fixed point.
    run_op({4{32'hd4d4d4d5}}, {4{32'hd5d5d7d6}}, 0, 1'b0, 1'b0, 128'h0);
    run_op({4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}, 1, 1'b0, 1'b0, 128'h0);

    // Backpressure with a second state offered during the stall.
    v = {$urandom, $urandom, $urandom, $urandom};
    e = {$urandom, $urandom, $urandom, $urandom};
    run_op(v, model(v, 1'b0), 10, 1'b0, 1'b1, e);
    run_op(e, model(e, 1'b0), 0, 1'b0, 1'b0, 128'h0);

    // Reset two cycles into an operation.
    bus.out_ready = 1'b1;
    send(128'h0123456789abcdef_fedcba9876543210);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    aborts++;
    #1;
    check_eq("abort_ctrl", {bus.in_ready, bus.out_valid}, 2'b10);
    check_eq("abort_data", bus.out_data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    v = 128'hdb135345_f20a225c_01010101_2d26314c;
    run_op(v, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 0, 1'b0, 1'b0, 128'h0);

`ifdef MIXCOLUMNS_INV_EN
    // Round trip forward then inverse, and mode toggling while busy.
    cur_inv = 1'b0;
    fw = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    run_op(v, fw, 0, 1'b1, 1'b0, 128'h0);
    cur_inv = 1'b1;
    run_op(fw, v, 2, 1'b1, 1'b0, 128'h0);
    check_eq("inv_model", model(fw, 1'b1), v);
`endif

    // Random states with random stalls.
    for (int n = 0; n < 1000; n++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
`ifdef MIXCOLUMNS_INV_EN
      cur_inv = 1'($urandom_range(0, 1));
`else
      cur_inv = 1'b0;
`endif
      run_op(v, model(v, cur_inv), $urandom_range(0, 3), 1'b0, 1'b0, 128'h0);
    end

    check_eq("hs_balance", 128'(out_fires), 128'(in_fires - aborts));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
